// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern table and decoder types.
// Patterns are active-low, index 0 = segment a, index 6 = segment g.
package seg7_pkg;

  localparam logic [0:6] SEG7_0     = 7'b0000001;
  localparam logic [0:6] SEG7_1     = 7'b1001111;
  localparam logic [0:6] SEG7_2     = 7'b0010010;
  localparam logic [0:6] SEG7_3     = 7'b0000110;
  localparam logic [0:6] SEG7_4     = 7'b1001100;
  localparam logic [0:6] SEG7_5     = 7'b0100100;
  localparam logic [0:6] SEG7_6     = 7'b0100000;
  localparam logic [0:6] SEG7_7     = 7'b0001101;
  localparam logic [0:6] SEG7_8     = 7'b0000000;
  localparam logic [0:6] SEG7_9     = 7'b0000100;
  localparam logic [0:6] SEG7_A     = 7'b0001000;
  localparam logic [0:6] SEG7_B     = 7'b1100000;
  localparam logic [0:6] SEG7_C     = 7'b0110001;
  localparam logic [0:6] SEG7_D     = 7'b1000010;
  localparam logic [0:6] SEG7_E     = 7'b0110000;
  localparam logic [0:6] SEG7_F     = 7'b0111000;
  localparam logic [0:6] SEG7_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: digit input bus and assembled-word outputs.
// master = pattern source, slave = decoder.
interface seg7_scan_decoder_if;
  logic [0:6]  seg;
  logic [2:0]  seg_idx;
  logic        seg_valid;
  logic        clear;
  logic [31:0] word;
  logic        word_valid;
  logic        word_err;
  logic [2:0]  bad_idx;
  logic        abort;
  logic        busy;

  modport master (
    output seg, seg_idx, seg_valid, clear,
    input  word, word_valid, word_err,
    input  bad_idx, abort, busy
  );

  modport slave (
    input  seg, seg_idx, seg_valid, clear,
    output word, word_valid, word_err,
    output bad_idx, abort, busy
  );
endinterface

// File: rtl/seg7_to_nibble.sv
// seg7_to_nibble: combinational active-low pattern to hex nibble.
// Unknown patterns (blank included) give nibble 0 with valid low.
module seg7_to_nibble
  import seg7_pkg::*;
(
  input  logic [0:6] pat,
  output logic [3:0] nib,
  output logic       valid
);

  // Reverse lookup of the shared encoder table.
  always_comb begin
    nib   = 4'h0;
    valid = 1'b1;
    unique case (pat)
      SEG7_0:  nib = 4'h0;
      SEG7_1:  nib = 4'h1;
      SEG7_2:  nib = 4'h2;
      SEG7_3:  nib = 4'h3;
      SEG7_4:  nib = 4'h4;
      SEG7_5:  nib = 4'h5;
      SEG7_6:  nib = 4'h6;
      SEG7_7:  nib = 4'h7;
      SEG7_8:  nib = 4'h8;
      SEG7_9:  nib = 4'h9;
      SEG7_A:  nib = 4'hA;
      SEG7_B:  nib = 4'hB;
      SEG7_C:  nib = 4'hC;
      SEG7_D:  nib = 4'hD;
      SEG7_E:  nib = 4'hE;
      SEG7_F:  nib = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: assembles eight decoded digits into a 32-bit word.
// Flags invalid digits, aborts stale partial frames after TIMEOUT cycles.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [7:0]    mask, mask_n;
  logic [31:0]   shadow, shadow_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  logic [2:0]    bad_q, bad_n;
  logic [31:0]   word_q, word_n;
  logic          werr_q, werr_n;
  logic [2:0]    bidx_q, bidx_n;
  logic          wv_q, wv_n;
  logic          ab_q, ab_n;
  logic [3:0]    dec_nib;
  logic          dec_ok;

  seg7_to_nibble u_dec (
    .pat   (bus.seg),
    .nib   (dec_nib),
    .valid (dec_ok)
  );

  // Frame FSM: emit, timeout, then clear/digit acceptance on top.
  always_comb begin
    state_n  = state;
    mask_n   = mask;
    shadow_n = shadow;
    cnt_n    = cnt;
    err_n    = err_q;
    bad_n    = bad_q;
    word_n   = word_q;
    werr_n   = werr_q;
    bidx_n   = bidx_q;
    wv_n     = 1'b0;
    ab_n     = 1'b0;
    unique case (state)
      ST_EMIT: begin
        word_n  = shadow;
        werr_n  = err_q;
        bidx_n  = bad_q;
        wv_n    = 1'b1;
        mask_n  = '0;
        err_n   = 1'b0;
        bad_n   = '0;
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
      ST_COLLECT: begin
        if (cnt == TLAST) begin
          ab_n    = 1'b1;
          mask_n  = '0;
          err_n   = 1'b0;
          bad_n   = '0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: cnt_n = '0;
    endcase
    if (bus.clear) begin
      mask_n  = '0;
      err_n   = 1'b0;
      bad_n   = '0;
      cnt_n   = '0;
      ab_n    = 1'b0;
      state_n = ST_IDLE;
    end else if (bus.seg_valid) begin
      mask_n[bus.seg_idx] = 1'b1;
      shadow_n[{bus.seg_idx, 2'b00} +: 4] = dec_nib;
      cnt_n = '0;
      ab_n  = 1'b0;
      if (!dec_ok && !err_n) begin
        err_n = 1'b1;
        bad_n = bus.seg_idx;
      end
      state_n = (&mask_n) ? ST_EMIT : ST_COLLECT;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mask   <= '0;
      shadow <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      bad_q  <= '0;
      word_q <= '0;
      werr_q <= 1'b0;
      bidx_q <= '0;
      wv_q   <= 1'b0;
      ab_q   <= 1'b0;
    end else begin
      state  <= state_n;
      mask   <= mask_n;
      shadow <= shadow_n;
      cnt    <= cnt_n;
      err_q  <= err_n;
      bad_q  <= bad_n;
      word_q <= word_n;
      werr_q <= werr_n;
      bidx_q <= bidx_n;
      wv_q   <= wv_n;
      ab_q   <= ab_n;
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = wv_q;
  assign bus.word_err   = werr_q;
  assign bus.bad_idx    = bidx_q;
  assign bus.abort      = ab_q;
  assign bus.busy       = (state == ST_COLLECT);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random frames against a
// transaction-level model of the digit-to-word assembly.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [0:6] tab [16];

  function automatic int dec(logic [0:6] p);
    for (int i = 0; i < 16; i++)
      if (tab[i] == p) return i;
    return -1;
  endfunction

  int          cyc = 0;
  int          vq [$];
  logic [31:0] wq [$];
  int          abq [$];

  always @(negedge clk) begin
    cyc++;
    if (bus.word_valid === 1'b1) begin
      vq.push_back(cyc);
      wq.push_back(bus.word);
    end
    if (bus.abort === 1'b1) abq.push_back(cyc);
  end

  task automatic send(logic [0:6] p, int idx);
    bus.seg       = p;
    bus.seg_idx   = 3'(idx);
    bus.seg_valid = 1'b1;
    @(negedge clk);
    bus.seg_valid = 1'b0;
  endtask

  task automatic idle(int n);
    bus.seg_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [0:6]  fp [$];
  int          fi [$];
  logic [31:0] last_word = '0;

  task automatic play(int maxgap, string tag);
    logic [3:0]  nib [8];
    bit          err;
    int          bad;
    int          d;
    logic [31:0] ew;
    for (int i = 0; i < 8; i++) nib[i] = 4'h0;
    err = 0;
    bad = 0;
    foreach (fp[k]) begin
      d = dec(fp[k]);
      nib[fi[k]] = (d < 0) ? 4'h0 : 4'(d);
      if (d < 0 && !err) begin
        err = 1;
        bad = fi[k];
      end
    end
    ew = {nib[7], nib[6], nib[5], nib[4],
          nib[3], nib[2], nib[1], nib[0]};
    vq.delete();
    foreach (fp[k]) begin
      send(fp[k], fi[k]);
      if (k < int'(fp.size()) - 1 && maxgap > 0)
        idle($urandom_range(maxgap, 0));
    end
    idle(1);
    chk({tag, "_valid"}, 32'(bus.word_valid), 32'd1);
    chk({tag, "_word"}, bus.word, ew);
    chk({tag, "_err"}, 32'(bus.word_err), 32'(err));
    chk({tag, "_bad"}, 32'(bus.bad_idx), 32'(bad));
    idle(1);
    chk({tag, "_pulse"}, 32'(bus.word_valid), 32'd0);
    chk({tag, "_npulse"}, 32'(vq.size()), 32'd1);
    last_word = ew;
    fp.delete();
    fi.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pm [8];
    int          j, t;
    logic [0:6]  p;
    logic [31:0] e1, e2;
    logic [3:0]  n;

    tab = '{SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5,
            SEG7_6, SEG7_7, SEG7_8, SEG7_9, SEG7_A, SEG7_B,
            SEG7_C, SEG7_D, SEG7_E, SEG7_F};
    rst = 1'b1;
    bus.seg = SEG7_BLANK;
    bus.seg_idx = 3'd0;
    bus.seg_valid = 1'b0;
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_word", bus.word, 32'h0);
    chk("rst_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_err", 32'(bus.word_err), 32'd0);
    chk("rst_bad", 32'(bus.bad_idx), 32'd0);
    chk("rst_abort", 32'(bus.abort), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    for (int k = 0; k < 8; k++) begin
      fp.push_back(tab[k + 1]);
      fi.push_back(7 - k);
    end
    play(0, "ord");
    chk("ord_const", bus.word, 32'h12345678);

    for (int k = 0; k < 7; k++) begin
      fp.push_back(SEG7_F);
      fi.push_back(k);
    end
    fp.push_back(SEG7_0); fi.push_back(3);
    fp.push_back(SEG7_F); fi.push_back(7);
    play(0, "ovw");
    chk("ovw_const", bus.word, 32'hFFFF0FFF);

    for (int k = 7; k >= 0; k--) begin
      p = (k == 5) ? SEG7_BLANK :
          (k == 2) ? 7'b1111110 : SEG7_0;
      fp.push_back(p);
      fi.push_back(k);
    end
    play(0, "inv");
    chk("inv_err_c", 32'(bus.word_err), 32'd1);
    chk("inv_bad_c", 32'(bus.bad_idx), 32'd5);

    abq.delete();
    send(SEG7_1, 0);
    send(SEG7_2, 1);
    send(SEG7_3, 2);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      chk($sformatf("to_abort%0d", k), 32'(bus.abort),
          32'(k == TO));
      if (k == TO - 1) chk("to_busy_pre", 32'(bus.busy), 32'd1);
      if (k == TO) chk("to_busy_post", 32'(bus.busy), 32'd0);
    end
    chk("to_word", bus.word, last_word);
    chk("to_nabort", 32'(abq.size()), 32'd1);
    for (int k = 0; k < 8; k++) begin
      fp.push_back(SEG7_9);
      fi.push_back(k);
    end
    play(0, "nine");
    chk("nine_const", bus.word, 32'h99999999);

    abq.delete();
    send(SEG7_4, 0);
    idle(TO - 1);
    send(SEG7_5, 1);
    idle(2);
    chk("tolast_noabort", 32'(abq.size()), 32'd0);
    chk("tolast_busy", 32'(bus.busy), 32'd1);
    idle(TO);
    chk("tolast_abort", 32'(abq.size()), 32'd1);

    e1 = '0;
    e2 = '0;
    vq.delete();
    wq.delete();
    for (int k = 7; k >= 0; k--) begin
      n = 4'($urandom_range(15, 0));
      e1[k * 4 +: 4] = n;
      send(tab[n], k);
    end
    for (int k = 0; k < 8; k++) begin
      n = 4'($urandom_range(15, 0));
      e2[k * 4 +: 4] = n;
      send(tab[n], k);
    end
    idle(3);
    chk("b2b_count", 32'(vq.size()), 32'd2);
    if (vq.size() >= 2) begin
      chk("b2b_w1", wq[0], e1);
      chk("b2b_w2", wq[1], e2);
      chk("b2b_gap", 32'(vq[1] - vq[0]), 32'd8);
    end
    last_word = e2;

    repeat (25) begin
      for (int i = 0; i < 8; i++) pm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = pm[i];
        pm[i] = pm[j];
        pm[j] = t;
      end
      for (int i = 0; i < 9; i++) begin
        if (i == 8) begin
          fi.push_back(pm[7]);
        end else if (i == 7) begin
          repeat ($urandom_range(2, 0))
            begin
              fi.push_back(pm[$urandom_range(6, 0)]);
            end
          continue;
        end else begin
          fi.push_back(pm[i]);
        end
      end
      foreach (fi[k]) begin
        if ($urandom_range(7, 0) == 0) begin
          do p = 7'($urandom_range(127, 0));
          while (dec(p) >= 0);
        end else begin
          p = tab[$urandom_range(15, 0)];
        end
        fp.push_back(p);
      end
      play(2, "rnd");
    end

    vq.delete();
    for (int k = 7; k >= 1; k--) send(tab[k], k);
    bus.clear = 1'b1;
    send(SEG7_0, 0);
    bus.clear = 1'b0;
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_word", bus.word, last_word);
    send(SEG7_0, 0);
    idle(2);
    chk("clr_nofire", 32'(vq.size()), 32'd0);
    chk("clr_busy_one", 32'(bus.busy), 32'd1);
    chk("clr_word2", bus.word, last_word);
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    chk("clr_idle", 32'(bus.busy), 32'd0);

    for (int k = 0; k < 8; k++) begin
      fp.push_back(SEG7_A);
      fi.push_back(k);
    end
    play(0, "pre_rst");
    send(SEG7_1, 0);
    send(SEG7_2, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_word", bus.word, 32'h0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_valid", 32'(bus.word_valid), 32'd0);
    chk("mrst_err", 32'(bus.word_err), 32'd0);
    chk("mrst_bad", 32'(bus.bad_idx), 32'd0);
    chk("mrst_abort", 32'(bus.abort), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      fp.push_back(tab[15 - k]);
      fi.push_back(k);
    end
    play(1, "post_rst");
    chk("post_rst_c", bus.word, 32'h89ABCDEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
